// File: rtl/mine_placer_if.sv
// Handshake bundle between game control and the mine placer.
// Game control drives the start request; the placer returns the bitmap.
interface mine_placer_if #(
   parameter int CELLS = 25,
   parameter int IDX_W = 5,
   parameter int CNT_W = 5
);
   logic             in_start;
   logic [15:0]      in_seed;
   logic [CNT_W-1:0] in_mines_num;
   logic [IDX_W-1:0] in_safe_idx;
   logic [CELLS-1:0] out_mines;
   logic [CNT_W-1:0] out_count;
   logic             out_busy;
   logic             out_done;

   modport master (
      output in_start, in_seed, in_mines_num, in_safe_idx,
      input  out_mines, out_count, out_busy, out_done
   );

   modport slave (
      input  in_start, in_seed, in_mines_num, in_safe_idx,
      output out_mines, out_count, out_busy, out_done
   );
endinterface

// File: rtl/mine_placer.sv
// LFSR-driven mine placement into a ROWS x COLS bitmap.
// Optional MINE_SAFE_CELL_EN keeps the first-click cell clear.
module mine_placer #(
   parameter int ROWS  = 5,
   parameter int COLS  = 5,
   parameter int CELLS = ROWS * COLS,
   parameter int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1,
   parameter int CNT_W = $clog2(CELLS + 1)
) (
   input logic         in_clka,
   input logic         in_rst_n,
   mine_placer_if.slave bus
);

   localparam logic [15:0] SEED_DEF = 16'hACE1;
`ifdef MINE_SAFE_CELL_EN
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CELLS - 1);
`else
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CELLS);
`endif

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d, lfsr_step;
   logic [CELLS-1:0] mines_q, mines_d;
   logic [CNT_W-1:0] count_q, count_d, count_inc;
   logic [CNT_W-1:0] target_q, target_d;
   logic [IDX_W-1:0] safe_q, safe_d;
   logic [IDX_W-1:0] cand;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             occupied, accept;

   assign lfsr_step = {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign cand      = lfsr_q[IDX_W-1:0];
   assign count_inc = count_q + CNT_W'(1);

   // Out-of-range candidates read as occupied so they are rejected.
   always_comb begin
      occupied = 1'b1;
      for (int i = 0; i < CELLS; i++)
         if (cand == IDX_W'(i)) occupied = mines_q[i];
   end

`ifdef MINE_SAFE_CELL_EN
   assign accept = !occupied && (cand != safe_q);
`else
   assign accept = !occupied;
`endif

   always_ff @(posedge in_clka or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED_DEF;
         mines_q  <= '0;
         count_q  <= '0;
         target_q <= '0;
         safe_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         mines_q  <= mines_d;
         count_q  <= count_d;
         target_q <= target_d;
         safe_q   <= safe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      mines_d  = mines_q;
      count_d  = count_q;
      target_d = target_q;
      safe_d   = safe_q;
      unique case (state_q)
         IDLE, DONE: begin
            // Inputs are captured here so they may change after the edge.
            if (bus.in_start) begin
               state_d  = LOAD;
               lfsr_d   = (bus.in_seed == 16'h0) ? SEED_DEF : bus.in_seed;
               target_d = (bus.in_mines_num > LIMIT) ? LIMIT
                                                     : bus.in_mines_num;
               safe_d   = bus.in_safe_idx;
            end
         end
         LOAD: begin
            mines_d = '0;
            count_d = '0;
            state_d = (target_q == '0) ? DONE : DRAW;
         end
         DRAW: begin
            lfsr_d = lfsr_step;
            if (accept) begin
               for (int i = 0; i < CELLS; i++)
                  if (cand == IDX_W'(i)) mines_d[i] = 1'b1;
               count_d = count_inc;
               if (count_inc == target_q) state_d = DONE;
            end
         end
      endcase
      busy_d = (state_d == LOAD) || (state_d == DRAW);
      done_d = (state_d == DONE);
   end

   assign bus.out_mines = mines_q;
   assign bus.out_count = count_q;
   assign bus.out_busy  = busy_q;
   assign bus.out_done  = done_q;

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: 5x5 and 8x8 instances.
// Expectations from hand values and a behavioural LFSR model.
module tb_mine_placer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

`ifdef MINE_SAFE_CELL_EN
   localparam bit SAFE_EN = 1'b1;
`else
   localparam bit SAFE_EN = 1'b0;
`endif

   mine_placer_if #(.CELLS(25), .IDX_W(5), .CNT_W(5)) ifa ();
   mine_placer_if #(.CELLS(64), .IDX_W(6), .CNT_W(7)) ifb ();

   mine_placer #(.ROWS(5), .COLS(5)) dut_a (
      .in_clka (clk),
      .in_rst_n(rst_n),
      .bus     (ifa.slave)
   );

   mine_placer #(.ROWS(8), .COLS(8)) dut_b (
      .in_clka (clk),
      .in_rst_n(rst_n),
      .bus     (ifb.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [15:0] seed, input int n,
                                 input int safe, input int cells,
                                 input int idx_w, output logic [63:0] m,
                                 output int cnt, output int cyc);
      logic [15:0] l;
      int lim, t, c;
      l   = (seed == 16'h0) ? 16'hACE1 : seed;
      lim = SAFE_EN ? cells - 1 : cells;
      t   = (n > lim) ? lim : n;
      m   = '0;
      cnt = 0;
      cyc = 0;
      while (cnt < t) begin
         c = int'(l) & ((1 << idx_w) - 1);
         if (c < cells && !m[c] && !(SAFE_EN && c == safe)) begin
            m[c] = 1'b1;
            cnt++;
         end
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         cyc++;
      end
   endfunction

   task automatic drive(input int sel, input logic st,
                        input logic [15:0] seed, input int n,
                        input int safe);
      if (sel == 0) begin
         ifa.in_start     = st;
         ifa.in_seed      = seed;
         ifa.in_mines_num = 5'(n);
         ifa.in_safe_idx  = 5'(safe);
      end else begin
         ifb.in_start     = st;
         ifb.in_seed      = seed;
         ifb.in_mines_num = 7'(n);
         ifb.in_safe_idx  = 6'(safe);
      end
   endtask

   function automatic logic [63:0] get_map(input int sel);
      return (sel == 0) ? 64'(ifa.out_mines) : 64'(ifb.out_mines);
   endfunction

   function automatic int get_cnt(input int sel);
      return (sel == 0) ? int'(ifa.out_count) : int'(ifb.out_count);
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? ifa.out_busy : ifb.out_busy;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? ifa.out_done : ifb.out_done;
   endfunction

   // Called #1 after a rising edge; returns edges from start edge to done.
   task automatic run(input int sel, input logic [15:0] seed, input int n,
                      input int safe, input bit spam,
                      output logic [63:0] m, output int cnt,
                      output int lat);
      drive(sel, 1'b1, seed, n, safe);
      @(posedge clk);
      #1;
      drive(sel, spam, 16'h5A5A, 3, 1);
      chk("busy_after_start", 64'(get_busy(sel)), 64'd1);
      lat = 0;
      while (!get_done(sel) && lat < 5000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      drive(sel, 1'b0, 16'h0, 0, 0);
      chk("done_reached", 64'(get_done(sel)), 64'd1);
      chk("busy_low_done", 64'(get_busy(sel)), 64'd0);
      m   = get_map(sel);
      cnt = get_cnt(sel);
   endtask

   task automatic run_vs_model(input string tag, input int sel,
                               input logic [15:0] seed, input int n,
                               input int safe, input bit spam,
                               output logic [63:0] m, output int lat);
      logic [63:0] em;
      int cnt, ecnt, ecyc;
      run(sel, seed, n, safe, spam, m, cnt, lat);
      model(seed, n, safe, (sel == 0) ? 25 : 64, (sel == 0) ? 5 : 6,
            em, ecnt, ecyc);
      chk({tag, "_map"}, m, em);
      chk({tag, "_cnt"}, 64'(cnt), 64'(ecnt));
      chk({tag, "_lat"}, 64'(lat), 64'(ecyc + 1));
   endtask

   initial begin
      logic [63:0] m0, m1;
      int c0, l0, l1;

      drive(0, 1'b0, 16'h0, 0, 0);
      drive(1, 1'b0, 16'h0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mines", get_map(0), 64'd0);
      chk("rst_count", 64'(get_cnt(0)), 64'd0);
      chk("rst_busy", 64'(get_busy(0)), 64'd0);
      chk("rst_done", 64'(get_done(0)), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero mines: one busy cycle, done at the following edge.
      run(0, 16'h0001, 0, 0, 1'b0, m0, c0, l0);
      chk("zero_map", m0, 64'd0);
      chk("zero_cnt", 64'(c0), 64'd0);
      chk("zero_lat", 64'(l0), 64'd1);

      // Over-request clamps to the board limit.
      run_vs_model("clamp", 0, 16'h1234, 31, 12, 1'b0, m0, l0);
      if (SAFE_EN) begin
         chk("clamp_cnt_hand", 64'(get_cnt(0)), 64'd24);
         chk("clamp_safe_bit", 64'(m0[12]), 64'd0);
         chk("clamp_pop", 64'($countones(m0)), 64'd24);
      end else begin
         chk("clamp_cnt_hand", 64'(get_cnt(0)), 64'd25);
         chk("clamp_full", m0, 64'h1FF_FFFF);
      end

      run_vs_model("seed0", 0, 16'h0000, 10, 0, 1'b0, m0, l0);
      run_vs_model("seedace1", 0, 16'hACE1, 10, 0, 1'b0, m1, l1);
      chk("seed0_eq_ace1", m0, m1);
      chk("seed0_pop", 64'($countones(m0)), 64'd10);

      run_vs_model("beef_a", 0, 16'hBEEF, 12, 3, 1'b0, m0, l0);
      run_vs_model("beef_b", 0, 16'hBEEF, 12, 3, 1'b0, m1, l1);
      chk("beef_map_rep", m0, m1);
      chk("beef_lat_rep", 64'(l0), 64'(l1));

      run_vs_model("calm", 0, 16'h0055, 8, 0, 1'b0, m0, l0);
      run_vs_model("spam", 0, 16'h0055, 8, 0, 1'b1, m1, l1);
      chk("spam_map_eq", m1, m0);
      chk("spam_lat_eq", 64'(l1), 64'(l0));

      // Async reset in the third DRAW cycle.
      drive(0, 1'b1, 16'h1234, 20, 5);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'h0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", 64'(get_busy(0)), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mines", get_map(0), 64'd0);
      chk("arst_count", 64'(get_cnt(0)), 64'd0);
      chk("arst_busy", 64'(get_busy(0)), 64'd0);
      chk("arst_done", 64'(get_done(0)), 64'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_busy", 64'(get_busy(0)), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_vs_model("post_rst", 0, 16'h1234, 20, 5, 1'b0, m0, l0);

      // 8x8 board, full request.
      run_vs_model("full", 1, 16'h0F0F, 64, 0, 1'b0, m0, l0);
      if (SAFE_EN) begin
         chk("full_cnt_hand", 64'(get_cnt(1)), 64'd63);
         chk("full_map_hand", m0, ~64'd1);
      end else begin
         chk("full_cnt_hand", 64'(get_cnt(1)), 64'd64);
         chk("full_map_hand", m0, {64{1'b1}});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mine_placer.md
# mine_placer

Parametrised mine-placement engine for the Minesweeper core. On a start pulse it seeds a 16-bit LFSR and draws pseudo-random cell indices, rejecting duplicates and out-of-range values, until exactly the requested number of distinct mines are set in a ROWS×COLS bitmap. It sits between the game-control FSM, which supplies the seed, mine count and first-click cell, and the board-state/adjacency logic, which consumes `out_mines`.

## Interface
- `ROWS`, default 5: board rows.
- `COLS`, default 5: board columns.
- `CELLS`, default ROWS*COLS: derived; must not be overridden.
- `IDX_W`, default $clog2(CELLS) (5): cell-index width; minimum 1.
- `CNT_W`, default $clog2(CELLS+1) (5): mine-count width.
- `in_clka`  in  1  clock, rising edge.
- `in_rst_n`  in  1  asynchronous active-low reset.
- `in_start`  in  1  start request; single-cycle pulse or level.
- `in_seed`  in  16  LFSR seed, sampled on accepted start.
- `in_mines_num`  in  CNT_W  requested mine count, sampled on accepted start.
- `in_safe_idx`  in  IDX_W  first-click cell, never mined; sampled on accepted start.
- `out_mines`  out  CELLS  mine bitmap; bit i = cell i, where i = row*COLS+col.
- `out_count`  out  CNT_W  mines placed so far.
- `out_busy`  out  1  high in LOAD and DRAW.
- `out_done`  out  1  high in DONE.

## Operation
- FSM states: IDLE, LOAD, DRAW, DONE.
- Reset: state IDLE; `out_mines`, `out_count`, `out_busy` and `out_done` all 0; LFSR = 16'hACE1; target = 0.
- IDLE or DONE with `in_start`=1: go to LOAD. A start is ignored in LOAD and DRAW.
- LOAD, one cycle:
  - lfsr ← `in_seed`, or 16'hACE1 if `in_seed`==0.
  - `out_mines` ← 0; `out_count` ← 0.
  - Latch the safe index.
  - target ← min(`in_mines_num`, LIMIT), where LIMIT = CELLS-1 with MINE_SAFE_CELL_EN, CELLS without it.
  - Next state: DONE if target==0, else DRAW.
- DRAW, one candidate per cycle:
  - cand = lfsr[IDX_W-1:0].
  - Accept iff cand<CELLS, `out_mines`[cand]==0, and (with MINE_SAFE_CELL_EN) cand≠safe.
  - On accept: set `out_mines`[cand]; `out_count`++.
  - The LFSR steps every DRAW cycle, whether the candidate is accepted or rejected.
  - When `out_count` would reach target on this cycle, go to DONE on the next edge.
- LFSR is Fibonacci, left-shift: new lsb = l[15]^l[13]^l[12]^l[10], i.e. x^16+x^14+x^13+x^11+1, period 65535.
  - The low IDX_W bits visit every value over one period, so DRAW always terminates.
- DONE: outputs hold until the next accepted start or reset.
- The result is fully deterministic for a given (seed, mines_num, safe_idx, parameters).

## Timing
- Start sampled at edge E → LOAD during cycle E+1 → DRAW starts at E+2, or DONE at E+2 when target==0.
- Best-case latency from start edge to `out_done`=1 is target+2 cycles.
- Rejections add one cycle each. There is no upper bound other than the LFSR period.
- `out_mines` and `out_count` update on the same edge as each accept. Consumers must use them only when `out_done`=1.
- `out_busy` and `out_done` are registered and mutually exclusive; both are 0 only in IDLE.
- Reset asserted mid-DRAW: immediate return to reset values. The partial bitmap is discarded.
- `in_seed`, `in_mines_num` and `in_safe_idx` may change freely after the start edge.
- `in_safe_idx` ≥ CELLS: no cell excluded; LIMIT stays CELLS-1.

## Configuration
- `MINE_SAFE_CELL_EN` defined:
  - Candidates equal to the latched `in_safe_idx` are rejected.
  - Target is clamped to CELLS-1.
- Not defined:
  - `in_safe_idx` is ignored (port kept for a stable interface).
  - Target is clamped to CELLS.
  - A full board (all cells mined) is reachable.

## Test plan
- Reset, then start with seed=0x0001, mines_num=0 → `out_busy` high for 1 cycle, `out_done`=1 at start+2, `out_mines`=0, `out_count`=0.
- Default 5×5, MINE_SAFE_CELL_EN, seed=0x1234, mines_num=31, safe=12 → `out_count`=24, popcount(`out_mines`)=24, bit 12=0; bitmap matches the reference LFSR model.
- Seed=0x0000 vs seed=0xACE1, mines_num=10 → identical `out_mines`; repeating seed=0xBEEF twice → identical maps and latencies.
- Start pulse asserted on every cycle while busy (seed 0x0055, 8 mines) → single run; result equals an undisturbed 8-mine run with seed 0x0055.
- `in_rst_n` low for 1 cycle at DRAW cycle 3 → all outputs 0 asynchronously, state IDLE; a subsequent start behaves exactly as from power-up.
- ROWS=8, COLS=8, macro undefined, mines_num=64 → `out_mines`=all ones, `out_count`=64, no hang.
